mario_motion: RTL
=================

MARIO_MOTION -- requirements
Module: mario_motion

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- STEP_X, 4, horizontal pixels per tick
- JUMP_V, 16, initial upward velocity (px/tick)
- VY_MAX, 16, terminal fall velocity
- X_MAX, 640, rightmost mario_x; beyond this the display scrolls instead
- Y_MAX, 832, lowest mario_y (896 - 64)
- X_RST, 64, reset mario_x
- Y_RST, 768, reset mario_y
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; reset is synchronous and active-low
- rst, in, 1, synchronous active-low reset
- tick, in, 1, one-cycle physics update strobe
- btn_left, in, 1, left held
- btn_right, in, 1, right held
- btn_jump, in, 1, jump held
- ground_below, in, 1, solid tile directly under feet
- wall_left, in, 1, solid tile adjacent left
- wall_right, in, 1, solid tile adjacent right
- head_hit, in, 1, solid tile directly above head
- mario_x, out, 11, sprite top-left x, screen pixels
- mario_y, out, 10, sprite top-left y, screen pixels
- mario_id, out, 6, sprite id to the object address decoder
- right, out, 1, rightward move accepted on last tick (scroll request)

Function
REQ-003 All state and outputs change only on a clk edge where tick=1 (latency 1 cycle); with tick=0 everything holds.
REQ-004 FSM states: STAND, WALK, JUMP, FALL.
REQ-005 Horizontal, evaluated every tick in every state: btn_right & !btn_left & !wall_right -> x = min(x+STEP_X, X_MAX), right=1, facing=R; btn_left & !btn_right & !wall_left -> x = max(x-STEP_X, 0) without underflow, right=0, facing=L; any other combination (both, neither, blocked) -> x held, right=0.
REQ-006 right=1 even when x already equals X_MAX (clamped); this drives the scroll.
REQ-007 STAND/WALK: !ground_below -> FALL with vy=0; else btn_jump -> JUMP with vy=JUMP_V; else horizontal move accepted -> WALK, otherwise STAND.
REQ-008 JUMP: head_hit -> FALL, vy=0, y held; else y = y - vy, saturating at 0; vy decrements by 1; on vy reaching 0, or y saturating at 0 -> FALL with vy=0.
REQ-009 FALL: ground_below -> y snapped down to multiple of 64 (y & ~63), vy=0, STAND/WALK per REQ-007; else y = min(y+vy, Y_MAX), vy = min(vy+1, VY_MAX); y reaching Y_MAX is treated as ground.
REQ-010 A held btn_jump does not re-trigger; a new jump requires btn_jump=0 for at least one tick in STAND/WALK.
REQ-011 Walk animation: 2-bit frame counter advances every 4 ticks in WALK, cycling 0,1,2,0; cleared on leaving WALK.
REQ-012 mario_id = base + (facing=L ? 16 : 0); base: STAND 1; WALK 2+frame; JUMP and FALL 5.
REQ-013 All arithmetic is unsigned at declared widths with explicit clamps; no wrap-around of x, y or vy.

Reset
REQ-014 rst=0 sampled at a clk edge (tick ignored) -> mario_x=X_RST, mario_y=Y_RST, mario_id=1, right=0, state STAND, vy=0, facing R, frame 0, jump latch clear; this is the same mid-jump or mid-fall.

Verification
REQ-015 Reset then 10 ticks with btn_right=1, ground_below=1 -> mario_x=104, state WALK, right=1, mario_id cycles 2,3,4.
REQ-016 x=636, btn_right=1 for 3 ticks -> mario_x 640,640,640, right=1 each tick.
REQ-017 btn_jump pulse from STAND at y=768, ground_below=0 after the first tick, head_hit=0 -> y=752 after the first tick, apex 632 after 16 ticks, then FALL, mario_id=5.
REQ-018 FALL with y=700, vy=3, ground_below=1 -> y=640, state STAND, vy=0.
REQ-019 btn_left=1, x=2 -> x=0, right=0; btn_left=btn_right=1 -> x unchanged, right=0; wall_right=1 with btn_right -> x unchanged, right=0.
REQ-020 rst=0 asserted mid-JUMP -> next edge outputs 64/768/1/0 regardless of tick.

Source files
------------

// File: rtl/mario_motion.sv
// mario_motion: per-tick motion and animation state for the player sprite.
//
// Ports:
//   clk          single clock
//   rst          synchronous active-low reset (sampled on clk, ignores tick)
//   tick         one-cycle physics strobe; state only advances on tick=1
//   btn_left     left held
//   btn_right    right held
//   btn_jump     jump held
//   ground_below solid tile directly under the feet
//   wall_left    solid tile adjacent on the left
//   wall_right   solid tile adjacent on the right
//   head_hit     solid tile directly above the head
//   mario_x      sprite top-left x (11 bits, screen pixels)
//   mario_y      sprite top-left y (10 bits, screen pixels)
//   mario_id     sprite id for the object address decoder
//   right        a rightward move was accepted on the last tick (scroll request)
module mario_motion #(
    parameter int STEP_X = 4,
    parameter int JUMP_V = 16,
    parameter int VY_MAX = 16,
    parameter int X_MAX  = 640,
    parameter int Y_MAX  = 832,
    parameter int X_RST  = 64,
    parameter int Y_RST  = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic        ground_below,
    input  logic        wall_left,
    input  logic        wall_right,
    input  logic        head_hit,
    output logic [10:0] mario_x,
    output logic [9:0]  mario_y,
    output logic [5:0]  mario_id,
    output logic        right
);

    typedef enum logic [1:0] {STAND, WALK, JUMP, FALL} state_t;

    // Vertical speed only needs to hold the larger of launch and terminal velocity.
    localparam int VW = $clog2(((JUMP_V > VY_MAX) ? JUMP_V : VY_MAX) + 1);

    localparam logic [11:0]   STEP_X_C = 12'(STEP_X);
    localparam logic [11:0]   X_MAX_C  = 12'(X_MAX);
    localparam logic [10:0]   Y_MAX_C  = 11'(Y_MAX);
    localparam logic [VW-1:0] JUMP_V_C = VW'(JUMP_V);
    localparam logic [VW-1:0] VY_MAX_C = VW'(VY_MAX);
    localparam logic [10:0]   X_RST_C  = 11'(X_RST);
    localparam logic [9:0]    Y_RST_C  = 10'(Y_RST);

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [VW-1:0] vy_q, vy_d;
    logic          right_q, right_d;
    logic          facing_l_q, facing_l_d;
    logic [1:0]    frame_q, frame_d;
    logic [1:0]    div_q, div_d;
    logic          jump_lock_q, jump_lock_d;

    logic          move_r, move_l;
    logic [11:0]   x_sum, x_dif;
    logic [10:0]   y_sum;
    logic [VW-1:0] vy_cur;
    logic          rising;
    state_t        ground_state;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        right_d     = 1'b0;
        facing_l_d  = facing_l_q;
        frame_d     = frame_q;
        div_d       = div_q;
        jump_lock_d = jump_lock_q;
        vy_cur      = vy_q;
        rising      = 1'b0;
        x_sum       = {1'b0, x_q} + STEP_X_C;
        x_dif       = {1'b0, x_q} - STEP_X_C;
        y_sum       = {1'b0, y_q} + 11'(vy_q);

        // Horizontal motion runs in every state, airborne included.
        move_r = btn_right & ~btn_left & ~wall_right;
        move_l = btn_left & ~btn_right & ~wall_left;
        if (move_r) begin
            x_d        = (x_sum > X_MAX_C) ? X_MAX_C[10:0] : x_sum[10:0];
            right_d    = 1'b1;  // asserted even when clamped: drives the scroll
            facing_l_d = 1'b0;
        end else if (move_l) begin
            x_d        = ({1'b0, x_q} < STEP_X_C) ? 11'd0 : x_dif[10:0];
            facing_l_d = 1'b1;
        end
        ground_state = (move_r | move_l) ? WALK : STAND;

        case (state_q)
            STAND, WALK: begin
                // Releasing jump while grounded re-arms the next jump.
                if (!btn_jump) jump_lock_d = 1'b0;
                if (!ground_below) begin
                    state_d = FALL;
                    vy_d    = '0;
                end else if (btn_jump && !jump_lock_q) begin
                    // Launch tick already applies the first upward step.
                    rising      = 1'b1;
                    vy_cur      = JUMP_V_C;
                    jump_lock_d = 1'b1;
                end else begin
                    state_d = ground_state;
                end
            end
            JUMP: rising = 1'b1;
            FALL: begin
                if (ground_below) begin
                    y_d     = y_q & ~10'd63;  // land on the tile grid
                    vy_d    = '0;
                    state_d = ground_state;
                end else if (y_sum >= Y_MAX_C) begin
                    // Bottom of the playfield acts as ground.
                    y_d     = Y_MAX_C[9:0];
                    vy_d    = '0;
                    state_d = ground_state;
                end else begin
                    y_d     = y_sum[9:0];
                    vy_d    = (vy_q >= VY_MAX_C) ? VY_MAX_C : vy_q + VW'(1);
                    state_d = FALL;
                end
            end
            default: state_d = STAND;
        endcase

        if (rising) begin
            if (head_hit) begin
                state_d = FALL;
                vy_d    = '0;
            end else if ({1'b0, y_q} <= 11'(vy_cur)) begin
                y_d     = '0;
                state_d = FALL;
                vy_d    = '0;
            end else begin
                y_d     = y_q - 10'(vy_cur);
                vy_d    = vy_cur - VW'(1);
                state_d = (vy_cur == VW'(1)) ? FALL : JUMP;
            end
        end

        // Animation frame steps every fourth tick spent continuously in WALK.
        if (state_q == WALK && state_d == WALK) begin
            if (div_q == 2'd3) begin
                div_d   = 2'd0;
                frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
            end else begin
                div_d = div_q + 2'd1;
            end
        end else begin
            div_d   = 2'd0;
            frame_d = 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= STAND;
            x_q         <= X_RST_C;
            y_q         <= Y_RST_C;
            vy_q        <= '0;
            right_q     <= 1'b0;
            facing_l_q  <= 1'b0;
            frame_q     <= 2'd0;
            div_q       <= 2'd0;
            jump_lock_q <= 1'b0;
        end else if (tick) begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            right_q     <= right_d;
            facing_l_q  <= facing_l_d;
            frame_q     <= frame_d;
            div_q       <= div_d;
            jump_lock_q <= jump_lock_d;
        end
    end

    logic [5:0] id_base;
    always_comb begin
        case (state_q)
            STAND:   id_base = 6'd1;
            WALK:    id_base = 6'd2 + {4'd0, frame_q};
            default: id_base = 6'd5;
        endcase
        mario_id = id_base + (facing_l_q ? 6'd16 : 6'd0);
    end

    assign mario_x = x_q;
    assign mario_y = y_q;
    assign right   = right_q;

endmodule
